// File: rtl/ram_dp_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
//   state_t          : clear-sequencer FSM state (CLEAR, RUN)
//   RDW_*            : same-port read-during-write mode selectors
//   READ_LAT_*       : legal read-latency values
package ram_dp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    localparam int READ_LAT_1 = 1;
    localparam int READ_LAT_2 = 2;

endpackage

// File: rtl/ram_dp_param_if.sv
// Bus interface for ram_dp_param: both request ports plus status outputs.
//   EN_X/WE_X/ADDR_X/DATA_X : request from master X (A or B)
//   Q_X/VALID_X             : read result and its strobe
//   BUSY, COLL              : clear in progress, write/write collision pulse
//   PERR_X                  : parity error flags (only with RAM_DP_PARITY_EN)
interface ram_dp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();
    logic              EN_A;
    logic              WE_A;
    logic [ADDR_W-1:0] ADDR_A;
    logic [DATA_W-1:0] DATA_A;
    logic [DATA_W-1:0] Q_A;
    logic              VALID_A;

    logic              EN_B;
    logic              WE_B;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] DATA_B;
    logic [DATA_W-1:0] Q_B;
    logic              VALID_B;

    logic              BUSY;
    logic              COLL;

`ifdef RAM_DP_PARITY_EN
    logic              PERR_A;
    logic              PERR_B;

    modport master (
        output EN_A, WE_A, ADDR_A, DATA_A, EN_B, WE_B, ADDR_B, DATA_B,
        input  Q_A, VALID_A, Q_B, VALID_B, BUSY, COLL, PERR_A, PERR_B
    );
    modport slave (
        input  EN_A, WE_A, ADDR_A, DATA_A, EN_B, WE_B, ADDR_B, DATA_B,
        output Q_A, VALID_A, Q_B, VALID_B, BUSY, COLL, PERR_A, PERR_B
    );
`else
    modport master (
        output EN_A, WE_A, ADDR_A, DATA_A, EN_B, WE_B, ADDR_B, DATA_B,
        input  Q_A, VALID_A, Q_B, VALID_B, BUSY, COLL
    );
    modport slave (
        input  EN_A, WE_A, ADDR_A, DATA_A, EN_B, WE_B, ADDR_B, DATA_B,
        output Q_A, VALID_A, Q_B, VALID_B, BUSY, COLL
    );
`endif
endinterface

// File: rtl/ram_dp_port_pipe.sv
// Per-port read pipeline: selects write-through or old data, registers it
// into Q with a VALID strobe, and adds a second stage when READ_LAT = 2.
// Optional macro RAM_DP_PARITY_EN adds a PERR flag aligned with VALID.
//   CLK, RST : clock, async active-high reset
//   acc, we  : request accepted this cycle / it is a write
//   wdata    : write data of the request
//   rdata    : stored word at the request address before the edge
//   q, valid : read result and strobe
//   perr     : parity mismatch on a read (parity build only)
module ram_dp_port_pipe
    import ram_dp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MEM_W    = 8,
    parameter int READ_LAT = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              acc,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MEM_W-1:0]  rdata,
    output logic [DATA_W-1:0] q,
    output logic              valid
`ifdef RAM_DP_PARITY_EN
    ,
    output logic              perr
`endif
);
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] q1;
    logic              valid1;

    assign sel_data = (we && (RDW_MODE == RDW_WRITE_FIRST)) ? wdata : rdata[DATA_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q1     <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= acc;
            if (acc) q1 <= sel_data;
        end
    end

`ifdef RAM_DP_PARITY_EN
    // Stored word carries even parity, so a read is bad when the XOR of all
    // stored bits is 1. Writes never flag.
    logic perr1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) perr1 <= 1'b0;
        else     perr1 <= acc && !we && (^rdata);
    end
`endif

    generate
        if (READ_LAT == READ_LAT_2) begin : g_lat2
            logic [DATA_W-1:0] q2;
            logic              valid2;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    q2     <= '0;
                    valid2 <= 1'b0;
                end else begin
                    valid2 <= valid1;
                    if (valid1) q2 <= q1;
                end
            end

            assign q     = q2;
            assign valid = valid2;

`ifdef RAM_DP_PARITY_EN
            logic perr2;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) perr2 <= 1'b0;
                else     perr2 <= perr1;
            end

            assign perr = perr2;
`endif
        end else begin : g_lat1
            assign q     = q1;
            assign valid = valid1;
`ifdef RAM_DP_PARITY_EN
            assign perr  = perr1;
`endif
        end
    endgenerate

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised true dual-port synchronous RAM with post-reset clear,
// write/write collision arbitration (port A wins) and per-port read pipes.
// Optional macro RAM_DP_PARITY_EN stores an even-parity bit per word.
//   CLK, RST : clock, async active-high reset
//   bus      : ram_dp_param_if slave (requests, Q/VALID, BUSY, COLL, PERR)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | zeroing mem[ptr] each cycle, BUSY = 1, port requests ignored
//   RUN   | normal operation, terminal until next reset
module ram_dp_param
    import ram_dp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1,
    parameter int RDW_MODE = 0
) (
    input logic           CLK,
    input logic           RST,
    ram_dp_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_DP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [MEM_W-1:0]  mem [DEPTH];
    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr, next_ptr;
    logic              busy;
    logic              acc_a, acc_b, wr_a, wr_b, coll_now, coll_q;
    logic [MEM_W-1:0]  wword_a, wword_b, rd_a, rd_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            CLEAR: begin
                next_ptr = ptr + ADDR_W'(1);
                if (ptr == PTR_LAST) next_state = RUN;
            end
            RUN: next_state = RUN;
            default: next_state = CLEAR;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign acc_a    = bus.EN_A && !busy;
    assign acc_b    = bus.EN_B && !busy;
    assign wr_a     = acc_a && bus.WE_A;
    assign wr_b     = acc_b && bus.WE_B;
    assign coll_now = wr_a && wr_b && (bus.ADDR_A == bus.ADDR_B);

`ifdef RAM_DP_PARITY_EN
    assign wword_a = {^bus.DATA_A, bus.DATA_A};
    assign wword_b = {^bus.DATA_B, bus.DATA_B};
`else
    assign wword_a = bus.DATA_A;
    assign wword_b = bus.DATA_B;
`endif

    // Asynchronous read of the pre-edge contents feeds both pipes, so the
    // cross-port reader and read-first mode both see the old word.
    assign rd_a = mem[bus.ADDR_A];
    assign rd_b = mem[bus.ADDR_B];

    // The array has no reset; the CLEAR sequence initialises it.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else begin
            if (wr_b && !coll_now) mem[bus.ADDR_B] <= wword_b;
            if (wr_a)              mem[bus.ADDR_A] <= wword_a;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) coll_q <= 1'b0;
        else     coll_q <= coll_now;
    end

    assign bus.BUSY = busy;
    assign bus.COLL = coll_q;

    ram_dp_port_pipe #(
        .DATA_W(DATA_W), .MEM_W(MEM_W), .READ_LAT(READ_LAT), .RDW_MODE(RDW_MODE)
    ) u_pipe_a (
        .CLK   (CLK),
        .RST   (RST),
        .acc   (acc_a),
        .we    (bus.WE_A),
        .wdata (bus.DATA_A),
        .rdata (rd_a),
        .q     (bus.Q_A),
        .valid (bus.VALID_A)
`ifdef RAM_DP_PARITY_EN
        ,
        .perr  (bus.PERR_A)
`endif
    );

    ram_dp_port_pipe #(
        .DATA_W(DATA_W), .MEM_W(MEM_W), .READ_LAT(READ_LAT), .RDW_MODE(RDW_MODE)
    ) u_pipe_b (
        .CLK   (CLK),
        .RST   (RST),
        .acc   (acc_b),
        .we    (bus.WE_B),
        .wdata (bus.DATA_B),
        .rdata (rd_b),
        .q     (bus.Q_B),
        .valid (bus.VALID_B)
`ifdef RAM_DP_PARITY_EN
        ,
        .perr  (bus.PERR_B)
`endif
    );

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the team's fixed 64x8 dual-port RAM.
- Adds configurable width and depth, a per-port enable, and selectable read-during-write mode.
- Adds 1- or 2-cycle read latency with a VALID strobe, write/write collision arbitration, and a post-reset memory-clear sequencer.
- Sits between the register-file/datapath blocks and any two independent masters that share a working memory.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
READ_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-port read-during-write: 0 = write-first (Q returns new data), 1 = read-first (Q returns old contents)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous reset, active-high
EN_A  input  1  port A request enable
WE_A  input  1  port A write enable (qualified by EN_A)
ADDR_A  input  ADDR_W  port A address
DATA_A  input  DATA_W  port A write data
Q_A  output  DATA_W  port A read data
VALID_A  output  1  Q_A holds the result of an accepted request
EN_B, WE_B, ADDR_B, DATA_B, Q_B, VALID_B  as port A, for port B
BUSY  output  1  memory-clear sequence in progress; all requests ignored
COLL  output  1  one-cycle pulse: write/write collision on the same address

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset values: Q_A = Q_B = 0, VALID_A = VALID_B = 0, COLL = 0, BUSY = 1, FSM = CLEAR, clear pointer = 0. Reset asserted mid-operation aborts the pipeline and restarts the clear sequence.
- FSM states: CLEAR and RUN.
  - CLEAR: writes 0 to address ptr and increments ptr each cycle. After writing DEPTH-1 (DEPTH cycles total), moves to RUN and BUSY drops to 0.
  - RUN: terminal state until the next reset.
- Request acceptance: a request is accepted when EN_X = 1 and BUSY = 0. In CLEAR, EN/WE inputs are ignored; no memory change from ports, no VALID.
- Write: accepted request with WE_X = 1 sets mem[ADDR_X] = DATA_X at the accepting edge.
- Read data:
  - Accepted read (WE_X = 0) returns mem[ADDR_X] as it was before that edge.
  - Accepted write returns DATA_X if RDW_MODE = 0, or the old mem[ADDR_X] if RDW_MODE = 1.
- Latency:
  - READ_LAT = 1: Q_X and VALID_X update at the accepting edge.
  - READ_LAT = 2: one extra register stage; Q_X and VALID_X appear one edge later.
  - VALID_X is 1 for exactly one cycle per accepted request. Back-to-back requests give a VALID every cycle.
  - Q_X holds its last value while VALID_X = 0.
- Write/write collision (both ports write, ADDR_A == ADDR_B): port A wins; mem gets DATA_A. COLL pulses 1 at the accepting edge, independent of READ_LAT. Port B's Q follows RDW_MODE using its own DATA_B (mode 0) or the old contents (mode 1).
- Cross-port read/write to the same address: the reading port always receives the old contents; no COLL.
- Address wrap: none needed. Addresses are full-range; ADDR_W bits address all DEPTH words.

Optional Feature:
- Macro: RAM_DP_PARITY_EN.
- Defined:
  - Each word is stored with an extra even-parity bit computed on write; CLEAR writes parity 0.
  - Adds outputs PERR_A and PERR_B (1 bit each), aligned with VALID_X, asserted when the read word's stored parity mismatches.
  - Writes never raise PERR. Reset value of PERR_A and PERR_B is 0.
- Undefined: no parity storage and no PERR ports; memory is exactly DATA_W bits wide.

Decomposition:
- Package ram_dp_pkg holds:
  - FSM state typedef (CLEAR, RUN).
  - RDW_MODE constants RDW_WRITE_FIRST = 0 and RDW_READ_FIRST = 1.
  - READ_LAT legal-value constants.
- One natural sub-module: ram_dp_port_pipe, instantiated once per port. It holds the request-to-Q/VALID pipeline (READ_LAT stages, RDW selection, and PERR alignment when RAM_DP_PARITY_EN is defined).
- The storage array, clear FSM and collision logic stay in the top level.

Test Plan:
- Clear sequence (defaults): release RST, drive EN_A = 1 throughout -> BUSY = 1 for exactly 64 cycles, no VALID_A; then read every address -> all Q_A = 0x00.
- Basic R/W, READ_LAT = 1: A writes 0x5A to addr 3, then B reads addr 3 -> Q_B = 0x5A with VALID_B one edge after the B request. With READ_LAT = 2, same stimulus -> VALID_B one edge later.
- RDW mode: addr 7 holds 0x11; A writes 0x22 to addr 7 -> Q_A = 0x22 with RDW_MODE = 0, Q_A = 0x11 with RDW_MODE = 1; a subsequent read of addr 7 returns 0x22 in both modes.
- Collision: both ports write addr 9 in the same cycle (A = 0xAA, B = 0xBB) -> COLL = 1 for one cycle; a later read of addr 9 returns 0xAA. Cross-port case: A writes 0xCC while B reads addr 9 in the same cycle -> Q_B = 0xAA, COLL = 0.
- Reset mid-stream: assert RST during back-to-back reads -> Q and VALID go to 0 immediately; BUSY = 1; full clear repeats; previously written data reads back 0x00.
- Parity (RAM_DP_PARITY_EN defined): write 0x0F, force-flip the stored parity bit via backdoor, read the word -> PERR_A = 1 aligned with VALID_A; a normal read of another word -> PERR_A = 0.
